// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, constants and address-check helper for the data-memory arbiter
package dmem_pkg;

  typedef enum logic {IDLE, ACCESS} arb_state_e;

  localparam int ADDR_LSB = 2;

  // Word-aligned and inside the memory's word range
  function automatic logic addr_ok(input logic [63:0] addr, input int depth);
    return (addr[ADDR_LSB-1:0] == '0) && ((addr >> ADDR_LSB) < 64'(depth));
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// rr_pick: round-robin one-hot grant, first valid bit at or above ptr, wrapping to the lowest
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [NREQ-1:0] hi;

  // Prefer the lowest valid bit at or above ptr; otherwise wrap to the lowest valid bit overall
  always_comb begin
    hi = valid & ~((NREQ'(1) << ptr) - NREQ'(1));
    grant = (|hi) ? hi & (~hi + NREQ'(1)) : valid & (~valid + NREQ'(1));
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-stage arbiter sharing one data memory port between requesters
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*WIDTH-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]    resp_valid,
  output logic [WIDTH-1:0]   resp_rdata,
  output logic               resp_err,
  output logic               mem_write,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic [CNT_W-1:0]   conflict_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] grant, gnt_q, gnt_d, resp_valid_q, resp_valid_d;
  logic write_q, write_d, resp_err_q, resp_err_d, err, accept, in_access;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, resp_rdata_q, resp_rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .valid(req_valid),
    .ptr  (rr_ptr_q),
    .grant(grant)
  );

  assign in_access    = (state_q == ACCESS);
  assign err          = ~addr_ok(64'(addr_q), DEPTH);
  assign accept       = (state_q == IDLE) & (|req_valid) & ~reset;
  assign req_ready    = accept ? grant : '0;
  assign mem_write    = in_access & write_q & ~err & ~reset;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign conflict_cnt = cnt_q;

  // Next state: latch the winner on accept, respond from the memory cycle, count contention
  always_comb begin
    state_d = accept ? ACCESS : IDLE;
    gnt_d = accept ? grant : gnt_q;
    rr_ptr_d = rr_ptr_q;
    write_d = write_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    for (int i = 0; i < NREQ; i++) begin
      if (accept && grant[i]) begin
        rr_ptr_d = PW'((i + 1) % NREQ);
        write_d = req_write[i];
        addr_d = req_addr[i*WIDTH +: WIDTH];
        wdata_d = req_wdata[i*WIDTH +: WIDTH];
      end
    end
    resp_valid_d = in_access ? gnt_q : '0;
    resp_err_d = in_access & err;
    resp_rdata_d = (in_access && !write_q && !err) ? mem_rdata : '0;
    cnt_d = (state_q == IDLE && $countones(req_valid) >= 2 && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      gnt_q <= '0;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      resp_valid_q <= '0;
      resp_err_q <= 1'b0;
      resp_rdata_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q <= gnt_d;
      write_q <= write_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;

  localparam int W  = 32;
  localparam int D  = 1024;
  localparam int N  = 2;
  localparam int CW = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic seed_mem = 1'b0;
  logic [N-1:0] req_valid = '0, req_write = '0, req_ready, resp_valid;
  logic [N*W-1:0] req_addr = '0, req_wdata = '0;
  logic [W-1:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic resp_err, mem_write;
  logic [CW-1:0] conflict_cnt;
  logic [31:0] tb_mem [D];
  logic [31:0] ref_mem [D];
  int ncmp = 0, nfail = 0, ptr = 0, exp_cnt = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.WIDTH(W), .DEPTH(D), .NREQ(N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // Data memory: combinational read, posedge write; out-of-range reads return junk
  assign mem_rdata = (mem_addr < 32'(D*4)) ? tb_mem[mem_addr[11:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (seed_mem)
      for (int i = 0; i < D; i++) tb_mem[i] <= ref_mem[i];
    else if (mem_write && mem_addr < 32'(D*4))
      tb_mem[mem_addr[11:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit aok(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < D);
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r < 7) return 32'($urandom_range(0, D-1)) << 2;
    if (r == 7) return (32'($urandom_range(0, D-1)) << 2) | 32'($urandom_range(1, 3));
    if (r == 8) return 32'(D*4) + (32'($urandom_range(0, 255)) << 2);
    return 32'($urandom);
  endfunction

  task automatic drive(input int who, input bit w, input logic [31:0] a, input logic [31:0] d);
    req_valid[who] = 1'b1;
    req_write[who] = w;
    req_addr[who*W +: W] = a;
    req_wdata[who*W +: W] = d;
  endtask

  task automatic chk_access(input bit w, input logic [31:0] a, input logic [31:0] d);
    chk("mem_write", mem_write, w && aok(a));
    chk("mem_addr", mem_addr, a);
    if (w && aok(a)) chk("mem_wdata", mem_wdata, d);
    chk("ready_access", req_ready, 0);
  endtask

  task automatic chk_resp(input int g, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit ok = aok(a);
    chk("resp_valid", resp_valid, 1 << g);
    chk("resp_err", resp_err, !ok);
    chk("resp_rdata", resp_rdata, (!w && ok) ? ref_mem[a/4] : 32'd0);
    if (w && ok) ref_mem[a/4] = d;
  endtask

  task automatic do_access(input int who, input bit w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    req_valid = '0;
    drive(who, w, a, d);
    @(negedge clk);
    chk("ready_single", req_ready, pick(req_valid, ptr) >= 0 ? 1 << pick(req_valid, ptr) : 0);
    chk("cnt_single", conflict_cnt, exp_cnt);
    @(posedge clk); #1;
    req_valid = '0;
    ptr = (who + 1) % N;
    @(negedge clk);
    chk_access(w, a, d);
    @(posedge clk);
    @(negedge clk);
    chk_resp(who, w, a, d);
    chk("mem_write_idle", mem_write, 0);
  endtask

  task automatic contend(input int n);
    bit w [N];
    logic [31:0] a [N], d [N];
    bit cw;
    logic [31:0] ca, cd;
    int g, pg;
    pg = -1;
    cw = 1'b0; ca = '0; cd = '0;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      w[i] = 1'($urandom_range(0, 1)); a[i] = rand_addr(); d[i] = $urandom;
      drive(i, w[i], a[i], d[i]);
    end
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      g = pick(req_valid, ptr);
      chk("ready_rr", req_ready, 1 << g);
      chk("cnt_rr", conflict_cnt, exp_cnt);
      if (pg >= 0) chk_resp(pg, cw, ca, cd);
      @(posedge clk);
      cw = w[g]; ca = a[g]; cd = d[g]; pg = g;
      ptr = (g + 1) % N;
      if (exp_cnt < CMAX) exp_cnt++;
      #1;
      w[g] = 1'($urandom_range(0, 1)); a[g] = rand_addr(); d[g] = $urandom;
      drive(g, w[g], a[g], d[g]);
      @(negedge clk);
      chk_access(cw, ca, cd);
      chk("cnt_access", conflict_cnt, exp_cnt);
      @(posedge clk);
    end
    @(negedge clk);
    req_valid = '0;
    chk_resp(pg, cw, ca, cd);
    chk("cnt_rr_end", conflict_cnt, exp_cnt);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ptr = 0;
    exp_cnt = 0;
  endtask

  initial begin
    int diffs;
    for (int i = 0; i < D; i++) ref_mem[i] = $urandom;
    seed_mem = 1'b1;
    @(posedge clk); #1 seed_mem = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cnt", conflict_cnt, 0);

    // Store then load back through the core port
    do_access(0, 1'b1, 32'h10, 32'hA5A5_0001);
    do_access(0, 1'b0, 32'h10, 32'h0);
    chk("store_load_0x10", ref_mem[4], 32'hA5A5_0001);

    // Both requesters contending from reset: grants alternate 0,1,0,1
    reset_dut();
    contend(4);

    // Misaligned DMA store, then confirm the neighbouring word is untouched
    do_access(1, 1'b1, 32'h6, 32'h1234_5678);
    do_access(0, 1'b0, 32'h4, 32'h0);

    // Out-of-range core load
    do_access(0, 1'b0, 32'h1000, 32'h0);

    // Reset during the memory cycle of a store to 0x20
    do_access(1, 1'b1, 32'h20, 32'h1111_2222);
    @(posedge clk); #1;
    req_valid = '0;
    drive(0, 1'b1, 32'h20, 32'h5555_6666);
    @(posedge clk); #1;
    req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_write", mem_write, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ptr = 0;
    exp_cnt = 0;
    @(negedge clk);
    chk("rst_mid_resp_valid", resp_valid, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    chk("rst_mid_mem_wdata", mem_wdata, 0);
    chk("rst_mid_ready", req_ready, 0);
    chk("rst_mid_cnt", conflict_cnt, 0);
    do_access(0, 1'b0, 32'h20, 32'h0);

    // Randomized single-requester traffic
    for (int t = 0; t < 60; t++)
      do_access($urandom_range(0, N-1), 1'($urandom_range(0, 1)), rand_addr(), $urandom);

    // Randomized contended traffic
    contend(8);

    // Continuous contention long enough to saturate the counter
    reset_dut();
    contend(CMAX + 8);
    chk("cnt_saturated", conflict_cnt, CMAX);

    repeat (2) @(posedge clk);
    @(negedge clk);
    diffs = 0;
    for (int i = 0; i < D; i++) if (tb_mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image", diffs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
